// File: rtl/mpu_cycle_controller.sv
// 6502 phase-2 clock / reset sequencer with step, breakpoint and trace-stall modes.
// Snapshot and cyc_cnt update one clk after the last high-phase clk; trace mode stalls with mpu_clk low until snap_ready.
module mpu_cycle_controller #(
  parameter int HALF_PERIOD = 25,
  parameter int RST_CYCLES  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  input  logic        step_pulse,
  input  logic        reset_req,
  input  logic        trace_en,
  input  logic        bp_en,
  input  logic [15:0] bp_addr,
  input  logic [15:0] addr_bus,
  input  logic [7:0]  data_bus,
  output logic        mpu_clk,
  output logic        mpu_rst_n,
  output logic [15:0] snap_addr,
  output logic [7:0]  snap_data,
  output logic        snap_valid,
  input  logic        snap_ready,
  output logic        halted,
  output logic [15:0] cyc_cnt
);

  localparam int PW = $clog2(HALF_PERIOD);
  localparam int RW = $clog2(RST_CYCLES);
  localparam logic [PW-1:0] HP_LAST  = PW'(HALF_PERIOD - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {S_RESET, S_LOW, S_HIGH, S_TRACE, S_IDLE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ph_cnt, ph_nxt;
  logic [RW-1:0] rst_cyc, rst_cyc_nxt;
  logic          rst_hi, rst_hi_nxt;
  logic          mpu_clk_nxt, mpu_rst_n_nxt;
  logic [15:0]   snap_addr_nxt, cyc_nxt;
  logic [7:0]    snap_data_nxt;
  logic          snap_valid_nxt, halted_nxt;
  logic          phase_end, bp_live, bp_snap;

  assign phase_end = (ph_cnt == HP_LAST);
  assign bp_live   = bp_en && (addr_bus == bp_addr);
  assign bp_snap   = bp_en && (snap_addr == bp_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RESET;
      ph_cnt     <= '0;
      rst_cyc    <= '0;
      rst_hi     <= 1'b0;
      mpu_clk    <= 1'b0;
      mpu_rst_n  <= 1'b0;
      snap_addr  <= '0;
      snap_data  <= '0;
      snap_valid <= 1'b0;
      halted     <= 1'b0;
      cyc_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      ph_cnt     <= ph_nxt;
      rst_cyc    <= rst_cyc_nxt;
      rst_hi     <= rst_hi_nxt;
      mpu_clk    <= mpu_clk_nxt;
      mpu_rst_n  <= mpu_rst_n_nxt;
      snap_addr  <= snap_addr_nxt;
      snap_data  <= snap_data_nxt;
      snap_valid <= snap_valid_nxt;
      halted     <= halted_nxt;
      cyc_cnt    <= cyc_nxt;
    end
  end

  // mpu_clk_nxt is the phase level of the clk being entered, so the output is a plain flop.
  always_comb begin
    state_nxt      = state;
    ph_nxt         = ph_cnt;
    rst_cyc_nxt    = rst_cyc;
    rst_hi_nxt     = rst_hi;
    mpu_clk_nxt    = 1'b0;
    mpu_rst_n_nxt  = mpu_rst_n;
    snap_addr_nxt  = snap_addr;
    snap_data_nxt  = snap_data;
    snap_valid_nxt = snap_valid;
    halted_nxt     = halted;
    cyc_nxt        = cyc_cnt;

    case (state)
      S_RESET: begin
        if (!phase_end) begin
          ph_nxt      = ph_cnt + 1'b1;
          mpu_clk_nxt = rst_hi;
        end else begin
          ph_nxt = '0;
          if (!rst_hi) begin
            rst_hi_nxt  = 1'b1;
            mpu_clk_nxt = 1'b1;
          end else begin
            rst_hi_nxt = 1'b0;
            if (rst_cyc == RST_LAST) begin
              rst_cyc_nxt   = '0;
              mpu_rst_n_nxt = 1'b1;
              state_nxt     = run_en ? S_LOW : S_IDLE;
            end else begin
              rst_cyc_nxt = rst_cyc + 1'b1;
            end
          end
        end
      end

      S_LOW: begin
        if (!phase_end) begin
          ph_nxt = ph_cnt + 1'b1;
        end else begin
          ph_nxt      = '0;
          state_nxt   = S_HIGH;
          mpu_clk_nxt = 1'b1;
        end
      end

      S_HIGH: begin
        if (!phase_end) begin
          ph_nxt      = ph_cnt + 1'b1;
          mpu_clk_nxt = 1'b1;
        end else begin
          ph_nxt        = '0;
          snap_addr_nxt = addr_bus;
          snap_data_nxt = data_bus;
          cyc_nxt       = cyc_cnt + 16'd1;
          if (trace_en) begin
            state_nxt      = S_TRACE;
            snap_valid_nxt = 1'b1;
          end else if (bp_live) begin
            state_nxt  = S_IDLE;
            halted_nxt = 1'b1;
          end else begin
            state_nxt = run_en ? S_LOW : S_IDLE;
          end
        end
      end

      S_TRACE: begin
        if (snap_ready) begin
          snap_valid_nxt = 1'b0;
          if (bp_snap) begin
            state_nxt  = S_IDLE;
            halted_nxt = 1'b1;
          end else begin
            state_nxt = run_en ? S_LOW : S_IDLE;
          end
        end
      end

      S_IDLE: begin
        if (step_pulse) begin
          state_nxt  = S_LOW;
          halted_nxt = 1'b0;
        end else if (run_en && !halted) begin
          state_nxt = S_LOW;
        end else if (!run_en) begin
          halted_nxt = 1'b0;
        end
      end

      default: state_nxt = S_RESET;
    endcase

    // Truncates any partial phase; snapshot contents are left as last captured.
    if (reset_req) begin
      state_nxt      = S_RESET;
      ph_nxt         = '0;
      rst_cyc_nxt    = '0;
      rst_hi_nxt     = 1'b0;
      mpu_clk_nxt    = 1'b0;
      mpu_rst_n_nxt  = 1'b0;
      snap_valid_nxt = 1'b0;
      halted_nxt     = 1'b0;
      cyc_nxt        = '0;
    end
  end

endmodule

// File: tb/tb_mpu_cycle_controller.sv
// Directed bench for mpu_cycle_controller with HALF_PERIOD=2, RST_CYCLES=2.
module tb_mpu_cycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_en, step_pulse, reset_req, trace_en, bp_en, snap_ready;
  logic [15:0] bp_addr, addr_bus;
  logic [7:0]  data_bus;
  logic        mpu_clk, mpu_rst_n, snap_valid, halted;
  logic [15:0] snap_addr, cyc_cnt;
  logic [7:0]  snap_data;

  int checks = 0;
  int failures = 0;

  mpu_cycle_controller #(.HALF_PERIOD(2), .RST_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_en     (run_en),
    .step_pulse (step_pulse),
    .reset_req  (reset_req),
    .trace_en   (trace_en),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .addr_bus   (addr_bus),
    .data_bus   (data_bus),
    .mpu_clk    (mpu_clk),
    .mpu_rst_n  (mpu_rst_n),
    .snap_addr  (snap_addr),
    .snap_data  (snap_data),
    .snap_valid (snap_valid),
    .snap_ready (snap_ready),
    .halted     (halted),
    .cyc_cnt    (cyc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at the first clk of a reset sequence: 0,0,1,1,0,0,1,1 then release.
  task automatic chk_rst_seq(input string tag);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      chk({tag, "_mpu_clk"}, 32'(mpu_clk), (k < 8 && (k % 4) >= 2) ? 1 : 0);
      chk({tag, "_mpu_rst_n"}, 32'(mpu_rst_n), (k == 8) ? 1 : 0);
    end
  endtask

  initial begin
    int          sv_seen, bad, c0;
    logic        prev;
    bit          done;

    rst_n = 1'b0; run_en = 1'b0; step_pulse = 1'b0; reset_req = 1'b0;
    trace_en = 1'b0; bp_en = 1'b0; bp_addr = '0; addr_bus = '0;
    data_bus = '0; snap_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc_cnt", 32'(cyc_cnt), 0);
    chk("rst_snap_addr", 32'(snap_addr), 0);
    chk("rst_snap_data", 32'(snap_data), 0);
    chk("rst_snap_valid", 32'(snap_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_rst_seq("por");
    chk("por_cyc_cnt", 32'(cyc_cnt), 0);
    chk("por_halted", 32'(halted), 0);
    tick();
    chk("por_idle_clk", 32'(mpu_clk), 0);

    // Single step; a second pulse during S_LOW must be ignored.
    addr_bus = 16'hFFFC; data_bus = 8'hEA;
    step_pulse = 1'b1;
    sv_seen = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      step_pulse = (k == 1);
      if (snap_valid) sv_seen++;
      chk("step_mpu_clk", 32'(mpu_clk), (k == 3 || k == 4) ? 1 : 0);
      if (k == 4) chk("step_cyc_before", 32'(cyc_cnt), 0);
      if (k == 5) chk("step_cyc_after", 32'(cyc_cnt), 1);
    end
    step_pulse = 1'b0;
    chk("step_snap_addr", 32'(snap_addr), 'hFFFC);
    chk("step_snap_data", 32'(snap_data), 'hEA);
    chk("step_cyc_cnt", 32'(cyc_cnt), 1);
    chk("step_snap_valid", 32'(sv_seen), 0);

    // Breakpoint at 0x8003 with address advancing after each falling mpu_clk.
    addr_bus = 16'h8000; bp_addr = 16'h8003; bp_en = 1'b1; run_en = 1'b1;
    prev = mpu_clk; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (prev && !mpu_clk) addr_bus = addr_bus + 16'd1;
      prev = mpu_clk;
      done = halted;
    end
    chk("bp_halted", 32'(halted), 1);
    chk("bp_snap_addr", 32'(snap_addr), 'h8003);
    chk("bp_cyc_cnt", 32'(cyc_cnt), 5);
    chk("bp_mpu_clk", 32'(mpu_clk), 0);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (mpu_clk || !halted) bad++;
    end
    chk("bp_hold", 32'(bad), 0);

    // Step out of halt, then reset_req (with a coincident step) mid S_HIGH.
    step_pulse = 1'b1;
    tick();
    step_pulse = 1'b0;
    chk("bp_step_halted", 32'(halted), 0);
    tick();
    tick();
    chk("mid_high_clk", 32'(mpu_clk), 1);
    chk("mid_high_cyc", 32'(cyc_cnt), 5);
    run_en = 1'b0; bp_en = 1'b0;
    reset_req = 1'b1; step_pulse = 1'b1;
    tick();
    reset_req = 1'b0; step_pulse = 1'b0;
    chk("rreq_cyc_cnt", 32'(cyc_cnt), 0);
    chk("rreq_snap_valid", 32'(snap_valid), 0);
    chk("rreq_halted", 32'(halted), 0);
    chk_rst_seq("rreq");

    // Trace stall: snap_valid rises at clk 5, holds with mpu_clk low.
    trace_en = 1'b1; addr_bus = 16'h1234; data_bus = 8'h5A;
    step_pulse = 1'b1;
    tick();
    step_pulse = 1'b0;
    tick(); tick(); tick();
    chk("tr_valid_k4", 32'(snap_valid), 0);
    tick();
    chk("tr_valid_k5", 32'(snap_valid), 1);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!snap_valid || mpu_clk) bad++;
    end
    chk("tr_stall", 32'(bad), 0);
    chk("tr_snap_addr", 32'(snap_addr), 'h1234);
    chk("tr_cyc_cnt", 32'(cyc_cnt), 1);
    run_en = 1'b1; snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
    chk("tr_hs_valid", 32'(snap_valid), 0);
    chk("tr_hs_low0", 32'(mpu_clk), 0);
    tick();
    chk("tr_hs_low1", 32'(mpu_clk), 0);
    tick();
    chk("tr_hs_high", 32'(mpu_clk), 1);

    // Trace off: free-run must complete exactly one cycle every 4 clks.
    trace_en = 1'b0;
    c0 = int'(cyc_cnt);
    sv_seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (snap_valid) sv_seen++;
    end
    chk("run_cyc_cnt", 32'(cyc_cnt), 32'(c0 + 10));
    chk("run_snap_valid", 32'(sv_seen), 0);

    run_en = 1'b0;
    repeat (8) tick();
    chk("stop_clk", 32'(mpu_clk), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
